// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller
// 32 x 64-bit lines, no write-allocate, single outstanding memory request.
module dcache_ctrl #(
   parameter int LSQSZ = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             except,
   input  logic             wr_en,
   input  logic [7:0]       wr_tag,
   input  logic [4:0]       wr_idx,
   input  logic [2:0]       wr_offset,
   input  logic [63:0]      wr_data,
   input  logic [1:0]       wr_size,
   output logic             wr_ack,
   input  logic [LSQSZ-1:0] rd_en,
   input  logic [7:0]       rd_tag,
   input  logic [4:0]       rd_idx,
   input  logic [2:0]       rd_offset,
   input  logic [1:0]       rd_size,
   output logic [LSQSZ-1:0] rd_feedback,
   output logic [63:0]      rd_data,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_req_store,
   output logic [15:0]      mem_addr,
   output logic [63:0]      mem_wdata,
   output logic [7:0]       mem_wmask,
   input  logic             mem_resp_valid,
   input  logic [63:0]      mem_resp_data
);

   typedef enum logic [2:0] {IDLE, WR_MEM, RD_REQ, RD_WAIT, RESP} state_t;

   state_t state, state_nxt;

   logic [31:0]      valid;
   logic [7:0]       tags  [32];
   logic [63:0]      lines [32];

   logic             drop;
   logic [LSQSZ-1:0] l_entry;
   logic [7:0]       l_tag;
   logic [4:0]       l_idx;
   logic [2:0]       l_off;
   logic [1:0]       l_size;
   logic [63:0]      l_wdata;
   logic [7:0]       l_wmask;
   logic [63:0]      rdata_q;

   function automatic logic [2:0] lane_base(input logic [2:0] off, input logic [1:0] sz);
      case (sz)
         2'd0:    return off;
         2'd1:    return {off[2:1], 1'b0};
         2'd2:    return {off[2], 2'b00};
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] sz);
      logic [7:0] cnt;
      case (sz)
         2'd0:    cnt = 8'h01;
         2'd1:    cnt = 8'h03;
         2'd2:    cnt = 8'h0F;
         default: cnt = 8'hFF;
      endcase
      return cnt << lane_base(off, sz);
   endfunction

   function automatic logic [63:0] expand(input logic [7:0] m);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   function automatic logic [63:0] extract(input logic [63:0] line, input logic [2:0] off,
                                           input logic [1:0] sz);
      return (line >> {lane_base(off, sz), 3'b000}) & expand(lane_mask(3'd0, sz));
   endfunction

   logic             wr_hit, rd_hit, accept_wr, accept_rd, fill;
   logic [7:0]       wr_m;
   logic [63:0]      wr_image;
   logic [LSQSZ-1:0] rd_sel;

   // A missing store has no line to merge with, so unwritten lanes of its image are zero.
   always_comb begin
      wr_hit    = valid[wr_idx] && (tags[wr_idx] == wr_tag);
      rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
      wr_m      = lane_mask(wr_offset, wr_size);
      wr_image  = ((wr_hit ? lines[wr_idx] : 64'd0) & ~expand(wr_m))
                | ((wr_data << {lane_base(wr_offset, wr_size), 3'b000}) & expand(wr_m));
      rd_sel    = rd_en & (~rd_en + LSQSZ'(1));
      accept_wr = (state == IDLE) && wr_en;
      accept_rd = (state == IDLE) && !wr_en && !except && (|rd_en);
      fill      = (state == RD_WAIT) && mem_resp_valid;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (wr_en) state_nxt = WR_MEM;
                  else if (accept_rd) state_nxt = rd_hit ? RESP : RD_REQ;
         WR_MEM:  if (mem_req_ready) state_nxt = IDLE;
         RD_REQ:  if (mem_req_ready) state_nxt = RD_WAIT;
         RD_WAIT: if (mem_resp_valid) state_nxt = (drop || except) ? IDLE : RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_ack        = 1'b0;
      rd_feedback   = '0;
      rd_data       = 64'd0;
      mem_req_valid = 1'b0;
      mem_req_store = 1'b0;
      mem_addr      = 16'd0;
      mem_wdata     = 64'd0;
      mem_wmask     = 8'd0;
      case (state)
         WR_MEM: begin
            mem_req_valid = 1'b1;
            mem_req_store = 1'b1;
            mem_addr      = {l_tag, l_idx, 3'b000};
            mem_wdata     = l_wdata;
            mem_wmask     = l_wmask;
            wr_ack        = mem_req_ready;
         end
         RD_REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {l_tag, l_idx, 3'b000};
         end
         RESP: if (!except) begin
            rd_feedback = l_entry;
            rd_data     = rdata_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid   <= '0;
         drop    <= 1'b0;
         l_entry <= '0;
         l_tag   <= '0;
         l_idx   <= '0;
         l_off   <= '0;
         l_size  <= '0;
         l_wdata <= '0;
         l_wmask <= '0;
         rdata_q <= '0;
      end else begin
         if (accept_wr) begin
            l_tag   <= wr_tag;
            l_idx   <= wr_idx;
            l_wdata <= wr_image;
            l_wmask <= wr_m;
         end else if (accept_rd) begin
            l_entry <= rd_sel;
            l_tag   <= rd_tag;
            l_idx   <= rd_idx;
            l_off   <= rd_offset;
            l_size  <= rd_size;
            rdata_q <= extract(lines[rd_idx], rd_offset, rd_size);
            drop    <= 1'b0;
         end
         // A flushed miss still completes and fills; only its response is dropped.
         if (except && (state == RD_REQ || state == RD_WAIT)) drop <= 1'b1;
         if (fill) begin
            valid[l_idx] <= 1'b1;
            rdata_q      <= extract(mem_resp_data, l_off, l_size);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (accept_wr && wr_hit) begin
            lines[wr_idx] <= wr_image;
         end else if (fill) begin
            lines[l_idx] <= mem_resp_data;
            tags[l_idx]  <= l_tag;
         end
      end
   end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Data-cache controller answering the load/store queue's DCache read and write requests. Holds a direct-mapped, write-through, no-write-allocate cache of 32 lines × 64 bits. Returns load data tagged by the one-hot LQ entry that asked for it. Services misses and committed stores through a single-outstanding memory request port.

## Interface
Parameters:
- LSQSZ, 16, LQ entries; width of the one-hot `rd_en`/`rd_feedback` vectors.

Ports:
- clock  in  1  rising-edge clock; the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- except  in  1  pipeline flush; cancels any pending load response.
- wr_en  in  1  store request from the LSQ; held until `wr_ack`.
- wr_tag / wr_idx / wr_offset  in  8/5/3  store address.
- wr_data  in  64  store data, right-aligned (byte 0 = LSB).
- wr_size  in  2  BYTE=0, HALF=1, WORD=2, DOUBLE=3.
- wr_ack  out  1  one-cycle pulse; store accepted by memory.
- rd_en  in  LSQSZ  one-hot LQ entry requesting a load; held until `rd_feedback`.
- rd_tag / rd_idx / rd_offset / rd_size  in  8/5/3/2  load address and size.
- rd_feedback  out  LSQSZ  one-cycle, one-hot pulse naming the answered entry.
- rd_data  out  64  load data, zero-extended, valid with `rd_feedback`.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_store  out  1  1 = store, 0 = load.
- mem_addr  out  16  equals {tag, idx, 3'b000}.
- mem_wdata  out  64  full merged 64-bit line/word image, for stores.
- mem_wmask  out  8  byte-enable mask, for stores.
- mem_resp_valid  in  1  load data returning.
- mem_resp_data  in  64  returned 8-byte block.

## Operation
- Each line holds: valid, an 8-bit tag and 64 bits of data. Hit = valid && tag match at the index.
- Byte lane handling:
  - Offset low bits are ignored per size: HALF ignores bit 0, WORD ignores bits 1:0, DOUBLE ignores all offset bits.
  - Lane base = aligned offset; lane count = 1/2/4/8.
  - Read: `rd_data` = line >> (8·base), masked to the lane count.
  - Write: merge `wr_data` into those lanes only; `mem_wmask` marks the same lanes.
- FSM states:
  - IDLE:
    - If `wr_en` is high: store takes priority over a read. Latch the request. If the store hits, merge it into the line this cycle. Go to WR_MEM.
    - Else if `rd_en` is nonzero: serve the lowest set bit; latch its entry and address.
      - Hit: latch the extracted data and go to RESP.
      - Miss: go to RD_REQ.
  - WR_MEM: drive `mem_req_valid`, `mem_req_store`=1, `mem_addr`, `mem_wdata` and `mem_wmask`. On `mem_req_ready`, pulse `wr_ack` in the same cycle and go to IDLE.
  - RD_REQ: drive `mem_req_valid`, `mem_req_store`=0 and the block address. On `mem_req_ready`, go to RD_WAIT.
  - RD_WAIT: on `mem_resp_valid`, fill the line (valid=1, tag, data) and latch the extracted data.
    - If the drop flag is clear: go to RESP.
    - If it is set: go to IDLE.
  - RESP: drive `rd_feedback` (latched entry) and `rd_data` for one cycle, then go to IDLE.
- Flush (`except`) handling:
  - `except` in RD_REQ or RD_WAIT sets the drop flag. The memory read still completes and still fills the line.
  - `except` in RESP suppresses the pulse: `rd_feedback` is 0 and the FSM goes to IDLE.
  - `except` in IDLE blocks acceptance of reads that cycle. A store may still be accepted.
  - Stores are never cancelled.
- A store that misses leaves the cache unchanged (no write-allocate).

## Timing
- Read hit: `rd_en` sampled in IDLE at edge T; `rd_feedback` and `rd_data` are high during cycle T+1. A new request can be accepted at T+2.
- Read miss: `mem_req_valid` is asserted from T+1 until the ready handshake. Response comes the cycle after `mem_resp_valid`.
- Store: `mem_req_valid` from T+1; `wr_ack` in the handshake cycle. No new request is accepted in that same cycle.
- Only one memory request is ever outstanding. `mem_req_*` outputs stay stable while `mem_req_valid` is high and ready is low.
- `rd_en` deasserting mid-miss has no effect; the latched request completes.
- Reset (any state, including mid-miss):
  - State returns to IDLE; all valid bits, the drop flag and the latches are cleared.
  - `wr_ack`=0, `rd_feedback`=0, `rd_data`=0, `mem_req_valid`=0, `mem_req_store`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0.
  - A `mem_resp_valid` arriving after reset is ignored (IDLE).
- `rd_feedback` is never more than one-hot. It is 0 whenever the FSM is not in RESP.

## Test plan
- Cold load: `rd_en`=16'h0004, tag 8'h12, idx 3, DOUBLE.
  - Expect: `mem_req_valid` with `mem_addr`=16'h1218. Memory returns 64'h0807060504030201.
  - Expect: `rd_feedback`=16'h0004 and `rd_data`=64'h0807060504030201 the cycle after the response.
  - Then: a HALF load at offset 3 of the same address → hit at T+1, `rd_data`=64'h0403, no memory request.
- Store merge: after filling the line above, store BYTE 8'hAA at offset 5.
  - Expect: `mem_wmask`=8'h20, `wr_ack` pulse.
  - Expect: a following DOUBLE load hits with 64'h0807AA0504030201.
- Store miss: store WORD to idx 7 (line invalid).
  - Expect: memory write with `mem_wmask`=8'h0F.
  - Expect: a subsequent load to the same address misses (no allocate).
- Arbitration: `wr_en`=1 and `rd_en`=16'h0030 in the same cycle.
  - Expect: the store is served first; then entry 4 (mask 16'h0010) gets `rd_feedback` before entry 5.
- Flush: `except` pulsed in RD_WAIT.
  - Expect: no `rd_feedback`; the line is still filled (next load hits at T+1).
- Reset mid-miss: reset in RD_WAIT.
  - Expect: all outputs 0 and the previously filled line misses afterwards.
  - Expect: a late `mem_resp_valid` is ignored.
